prog_clockdiv: RTL and testbench

Parametrised, runtime-programmable clock divider for the real-time clock datapath. It generates a divided clock-enable waveform `oclk` with a programmable period and high time, plus a one-cycle `otick` pulse per period. New settings are loaded through a strobe and validated. Accepted settings are applied only at a period boundary, so output periods are never truncated. It sits between the system clock and the seconds/minutes counters.

---
 rtl/clockdiv_pkg.sv | 15 +
 rtl/prog_clockdiv_if.sv | 24 ++
 rtl/clockdiv_cfg.sv | 64 ++++++
 rtl/prog_clockdiv.sv | 76 +++++++
 tb/tb_prog_clockdiv.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/clockdiv_pkg.sv
// Shared types, constants and the config validity rule for the programmable clock divider.
package clockdiv_pkg;

  typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_t;

  localparam int MIN_DIV   = 2;
  localparam int CFG_MAX_W = 32;

  // Callers zero-extend their WIDTH-bit fields to CFG_MAX_W bits before calling.
  function automatic logic cfg_valid(input logic [CFG_MAX_W-1:0] div,
                                     input logic [CFG_MAX_W-1:0] high);
    return (div >= CFG_MAX_W'(MIN_DIV)) && (high <= div);
  endfunction

endpackage

// File: rtl/prog_clockdiv_if.sv
// Control/status bundle of the programmable clock divider.
interface prog_clockdiv_if #(
  parameter int WIDTH = 16
);
  logic             ien;
  logic             iload;
  logic [WIDTH-1:0] idiv;
  logic [WIDTH-1:0] ihigh;
  logic             oclk;
  logic             otick;
  logic             oack;
  logic             oerr;
  logic [WIDTH-1:0] ocount;

  modport master (
    output ien, iload, idiv, ihigh,
    input  oclk, otick, oack, oerr, ocount
  );

  modport slave (
    input  ien, iload, idiv, ihigh,
    output oclk, otick, oack, oerr, ocount
  );
endinterface

// File: rtl/clockdiv_cfg.sv
// Config path: validates loads, stages them, and applies them only on a period boundary or while frozen.
module clockdiv_cfg
  import clockdiv_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 25,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] high_a,
  output logic             apply,
  output logic             ack,
  output logic             err
);

  cfg_state_t       state;
  logic [WIDTH-1:0] div_s;
  logic [WIDTH-1:0] high_s;
  logic             boundary;
  logic             valid;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] high_next;

  always_comb begin
    boundary  = en && (count == (div_a - WIDTH'(1)));
    valid     = load && cfg_valid(CFG_MAX_W'(div_in), CFG_MAX_W'(high_in));
    // A load in the same cycle wins over whatever is already staged.
    apply     = (valid || (state == CFG_PENDING)) && (boundary || !en);
    div_next  = valid ? div_in  : div_s;
    high_next = valid ? high_in : high_s;
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state  <= CFG_IDLE;
      div_a  <= WIDTH'(DEFAULT_DIV);
      high_a <= WIDTH'(DEFAULT_HIGH);
      div_s  <= WIDTH'(DEFAULT_DIV);
      high_s <= WIDTH'(DEFAULT_HIGH);
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= load && !valid;
      ack <= apply;
      if (apply) begin
        div_a  <= div_next;
        high_a <= high_next;
        state  <= CFG_IDLE;
      end else if (valid) begin
        div_s  <= div_in;
        high_s <= high_in;
        state  <= CFG_PENDING;
      end
    end
  end

endmodule

// File: rtl/prog_clockdiv.sv
// Runtime-programmable clock-enable divider: period counter plus registered oclk/otick outputs.
module prog_clockdiv
  import clockdiv_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 25,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic            iclk,
  input  logic            irst_n,
  prog_clockdiv_if.slave  bus
);

  if (WIDTH < 2 || WIDTH > CFG_MAX_W) begin : g_bad_width
    $error("prog_clockdiv: WIDTH out of range");
  end
  if (DEFAULT_DIV < MIN_DIV || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_div
    $error("prog_clockdiv: DEFAULT_DIV out of range");
  end
  if (DEFAULT_HIGH < 0 || DEFAULT_HIGH > DEFAULT_DIV) begin : g_bad_high
    $error("prog_clockdiv: DEFAULT_HIGH out of range");
  end

  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] high_a;
  logic             apply;
  logic [WIDTH-1:0] count_p0;
  logic             clk_p1;
  logic             tick_p1;
  logic             wrap;

  clockdiv_cfg #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_HIGH (DEFAULT_HIGH)
  ) u_cfg (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .en      (bus.ien),
    .load    (bus.iload),
    .div_in  (bus.idiv),
    .high_in (bus.ihigh),
    .count   (count_p0),
    .div_a   (div_a),
    .high_a  (high_a),
    .apply   (apply),
    .ack     (bus.oack),
    .err     (bus.oerr)
  );

  assign wrap = (count_p0 == (div_a - WIDTH'(1)));

  // Stage p0 -> p1: oclk/otick are decided from the pre-increment count and the old config.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      count_p0 <= '0;
      clk_p1   <= 1'b0;
      tick_p1  <= 1'b0;
    end else begin
      tick_p1 <= bus.ien && wrap;
      if (bus.ien) begin
        clk_p1 <= (count_p0 < high_a);
      end
      if (apply) begin
        count_p0 <= '0;
      end else if (bus.ien) begin
        count_p0 <= wrap ? '0 : count_p0 + WIDTH'(1);
      end
    end
  end

  assign bus.ocount = count_p0;
  assign bus.oclk   = clk_p1;
  assign bus.otick  = tick_p1;

endmodule

// File: tb/tb_prog_clockdiv.sv
// Bench for prog_clockdiv: directed scenarios then random traffic, all checked against a period-level reference model.
module tb_prog_clockdiv;
  localparam int W = 16;

  logic iclk   = 1'b0;
  logic irst_n = 1'b0;
  always #5 iclk = ~iclk;

  prog_clockdiv_if #(.WIDTH(W)) bus();

  prog_clockdiv #(.WIDTH(W)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: active and staged config, position within the current period.
  int m_div, m_high, m_pos, s_div, s_high;
  bit m_pend;
  bit e_clk, e_tick, e_ack, e_err;

  int nhigh, ntick, nack, nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit en, input bit ld, input int d, input int h);
    bit last, good;
    if (!rn) begin
      m_div = 25; m_high = 12; m_pos = 0; m_pend = 0;
      e_clk = 0; e_tick = 0; e_ack = 0; e_err = 0;
      return;
    end
    last   = en && (m_pos == m_div - 1);
    good   = ld && (d >= 2) && (h <= d);
    e_tick = last;
    if (en) e_clk = (m_pos < m_high);
    e_err  = ld && !good;
    if ((good || m_pend) && (last || !en)) begin
      if (good) begin m_div = d; m_high = h; end
      else begin m_div = s_div; m_high = s_high; end
      m_pend = 0; m_pos = 0; e_ack = 1;
    end else begin
      e_ack = 0;
      if (good) begin s_div = d; s_high = h; m_pend = 1; end
      if (en) m_pos = (m_pos + 1) % m_div;
    end
  endtask

  task automatic cyc(input bit rn, input bit en, input bit ld, input int d, input int h);
    irst_n    = rn;
    bus.ien   = en;
    bus.iload = ld;
    bus.idiv  = W'(d);
    bus.ihigh = W'(h);
    @(posedge iclk);
    model_step(rn, en, ld, d, h);
    #1;
    chk("ocount", 32'(bus.ocount), 32'(m_pos));
    chk("oclk",   32'(bus.oclk),   32'(e_clk));
    chk("otick",  32'(bus.otick),  32'(e_tick));
    chk("oack",   32'(bus.oack),   32'(e_ack));
    chk("oerr",   32'(bus.oerr),   32'(e_err));
    nhigh += int'(bus.oclk);
    ntick += int'(bus.otick);
    nack  += int'(bus.oack);
    nerr  += int'(bus.oerr);
  endtask

  initial begin
    int d, h;
    bus.ien = 0; bus.iload = 0; bus.idiv = '0; bus.ihigh = '0;
    s_div = 25; s_high = 12;
    #2;

    // Reset defaults: 3 reset cycles, then 75 enabled cycles = 3 default periods.
    repeat (3) cyc(0, 1, 0, 0, 0);
    nhigh = 0; ntick = 0;
    repeat (75) cyc(1, 1, 0, 0, 0);
    chk("dflt_high_cycles", 32'(nhigh), 32'd36);
    chk("dflt_ticks", 32'(ntick), 32'd3);

    // Staged load at count 5: the 25-cycle period completes first, then 10/3 periods.
    repeat (5) cyc(1, 1, 0, 0, 0);
    nack = 0;
    cyc(1, 1, 1, 10, 3);
    repeat (19) cyc(1, 1, 0, 0, 0);
    chk("stage_ack_once", 32'(nack), 32'd1);
    nhigh = 0; ntick = 0;
    repeat (20) cyc(1, 1, 0, 0, 0);
    chk("div10_high_cycles", 32'(nhigh), 32'd6);
    chk("div10_ticks", 32'(ntick), 32'd2);

    // Rejected loads leave the period alone.
    nerr = 0;
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 8, 9);
    cyc(1, 1, 0, 0, 0);
    chk("reject_errs", 32'(nerr), 32'd2);
    repeat (15) cyc(1, 1, 0, 0, 0);

    // Overwrite while pending: only the last staged config takes effect.
    cyc(1, 1, 1, 10, 3);
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 6, 6);
    repeat (20) cyc(1, 1, 0, 0, 0);
    nhigh = 0;
    repeat (12) cyc(1, 1, 0, 0, 0);
    chk("div6_const_high", 32'(nhigh), 32'd12);

    // Freeze mid-period with a load during the freeze.
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 9, 4);
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (20) cyc(1, 1, 0, 0, 0);

    // Reset while pending drops the staged config.
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 10, 3);
    cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    nack = 0; ntick = 0;
    repeat (50) cyc(1, 1, 0, 0, 0);
    chk("rst_pend_no_ack", 32'(nack), 32'd0);
    chk("rst_pend_ticks", 32'(ntick), 32'd2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      d = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, d + 2));
      cyc(($urandom % 300) != 0, ($urandom % 6) != 0, ($urandom % 12) == 0, d, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
